adc_serial_capture: RTL and testbench



---
 rtl/adc_serial_capture_if.sv | 26 ++
 rtl/adc_serial_capture.sv | 120 ++++++++++++
 tb/tb_adc_serial_capture.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_capture_if.sv
// Capture-side strobes and valid/ready readout port of adc_serial_capture.
// The capture block is the slave; the producer/consumer side is the master.
interface adc_serial_capture_if #(
    parameter int DATA_W = 12
);
    logic              locked;
    logic              start_pulse;
    logic              edge_pulse;
    logic              sdata;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic              overrun;
    logic              overrun_clr;

    modport master (
        output locked, start_pulse, edge_pulse, sdata, data_ready, overrun_clr,
        input  data_out, data_valid, busy, overrun
    );

    modport slave (
        input  locked, start_pulse, edge_pulse, sdata, data_ready, overrun_clr,
        output data_out, data_valid, busy, overrun
    );
endinterface

// File: rtl/adc_serial_capture.sv
// Serial ADC frame capture (MSB first) with a one-word valid/ready holding register.
// Define ADC_AVG_EN to average 2^AVG_LOG2 frames per output word (AVG_LOG2 >= 1).
module adc_serial_capture #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    adc_serial_capture_if.slave  bus
);
    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    if (DATA_W < 2 || DATA_W > 32 || AVG_LOG2 < 0) begin : g_param_check
        $error("adc_serial_capture: DATA_W must be 2..32 and AVG_LOG2 non-negative");
    end

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_overrun;

    logic                w_start;
    logic                w_shift;
    logic                w_frame_done;
    logic [DATA_W-1:0]   w_frame_word;
    logic                w_emit;
    logic [DATA_W-1:0]   w_emit_word;

    // Start outranks a coincident strobe, even the last one of a frame.
    assign w_start      = bus.locked & bus.start_pulse;
    assign w_shift      = bus.locked & bus.edge_pulse & ~bus.start_pulse & (r_state == SHIFT);
    assign w_frame_done = w_shift & (r_cnt == LAST_BIT);
    assign w_frame_word = {r_shreg[DATA_W-2:0], bus.sdata};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_state <= SHIFT;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shreg <= w_frame_word;
            if (w_frame_done) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

`ifdef ADC_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_frames;
    logic [ACC_W-1:0]    w_acc_sum;

    assign w_acc_sum   = r_acc + ACC_W'(w_frame_word);
    assign w_emit      = w_frame_done & (&r_frames);
    // Selecting the upper DATA_W bits is the truncating divide by 2^AVG_LOG2.
    assign w_emit_word = w_acc_sum[AVG_LOG2 +: DATA_W];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc    <= '0;
            r_frames <= '0;
        end else if (w_frame_done) begin
            if (&r_frames) begin
                r_acc    <= '0;
                r_frames <= '0;
            end else begin
                r_acc    <= w_acc_sum;
                r_frames <= r_frames + 1'b1;
            end
        end
    end
`else
    assign w_emit      = w_frame_done;
    assign w_emit_word = w_frame_word;
`endif

    // A new word always wins the holding register; losing an unaccepted one is flagged.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_emit) begin
                r_data  <= w_emit_word;
                r_valid <= 1'b1;
            end else if (bus.data_ready) begin
                r_valid <= 1'b0;
            end

            if (w_emit & r_valid & ~bus.data_ready) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = (r_state == SHIFT);
endmodule

// File: tb/tb_adc_serial_capture.sv
// Randomised bench for adc_serial_capture: a cycle-level behavioural model checked every
// cycle, plus literal expectations from the directed scenarios.
module tb_adc_serial_capture;
    localparam int     DW   = 12;
    localparam int     AL   = 2;
    localparam longint MASK = (64'd1 << DW) - 1;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    adc_serial_capture_if #(.DATA_W(DW)) bus ();

    adc_serial_capture #(.DATA_W(DW), .AVG_LOG2(AL)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit     m_busy;
    int     m_bits;
    longint m_word;
    longint m_data;
    longint m_sum;
    int     m_n;
    bit     m_valid;
    bit     m_ovr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge nrst) begin
        bit     st, ed, emit;
        longint w;
        if (!nrst) begin
            m_busy = 0; m_bits = 0; m_word = 0; m_data = 0;
            m_sum = 0; m_n = 0; m_valid = 0; m_ovr = 0;
        end else begin
            emit = 0;
            w    = 0;
            st   = bus.locked && bus.start_pulse;
            ed   = bus.locked && bus.edge_pulse;
            if (st) begin
                m_busy = 1; m_bits = 0; m_word = 0;
            end else if (m_busy && ed) begin
                m_word = ((m_word << 1) | longint'(bus.sdata)) & MASK;
                m_bits++;
                if (m_bits == DW) begin
                    m_busy = 0;
                    m_bits = 0;
`ifdef ADC_AVG_EN
                    m_sum += m_word;
                    m_n++;
                    if (m_n == (1 << AL)) begin
                        emit = 1; w = m_sum >> AL; m_sum = 0; m_n = 0;
                    end
`else
                    emit = 1; w = m_word;
`endif
                end
            end
            if (m_valid && bus.data_ready)
                $display("txn accept data=0x%0h at %0t", m_data, $time);
            if (emit) begin
                if (m_valid && !bus.data_ready) m_ovr = 1;
                else if (bus.overrun_clr)      m_ovr = 0;
                m_data  = w;
                m_valid = 1;
            end else begin
                if (m_valid && bus.data_ready) m_valid = 0;
                if (bus.overrun_clr)           m_ovr = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("data_out",   64'(bus.data_out),   64'(m_data));
        check("data_valid", 64'(bus.data_valid), 64'(m_valid));
        check("busy",       64'(bus.busy),       64'(m_busy));
        check("overrun",    64'(bus.overrun),    64'(m_ovr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start_pulse = 1'b1;
        tick();
        bus.start_pulse = 1'b0;
    endtask

    task automatic send_bit(input bit b, input bit gap);
        bus.sdata      = b;
        bus.edge_pulse = 1'b1;
        tick();
        bus.edge_pulse = 1'b0;
        bus.sdata      = 1'($urandom);
        if (gap) repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_bits(input logic [31:0] word, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(word[i], i != lo);
    endtask

    task automatic frame(input logic [31:0] word);
        do_start();
        send_bits(word, DW - 1, 0);
    endtask

    task automatic accept();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        #3 nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
    endtask

    initial begin
        bus.locked = 1'b1; bus.start_pulse = 1'b0; bus.edge_pulse = 1'b0;
        bus.sdata = 1'b0; bus.data_ready = 1'b0; bus.overrun_clr = 1'b0;
        repeat (3) tick();
        nrst = 1'b1;
        check("rst_data", 64'(bus.data_out), 64'h0);
        check("rst_valid", 64'(bus.data_valid), 64'h0);

        // Single frame, handshake held off then accepted.
        do_start();
        check("t2_busy", 64'(bus.busy), 64'h1);
        send_bits(32'hA5C, 11, 0);
`ifndef ADC_AVG_EN
        check("t2_data", 64'(bus.data_out), 64'hA5C);
        check("t2_valid", 64'(bus.data_valid), 64'h1);
`endif
        check("t2_idle", 64'(bus.busy), 64'h0);
        repeat (3) tick();
        accept();
        check("t2_drop", 64'(bus.data_valid), 64'h0);

        // Lock loss mid-frame freezes capture.
        do_start();
        send_bits(32'h3F1, 11, 7);
        bus.locked = 1'b0;
        bus.edge_pulse = 1'b1; tick();
        bus.edge_pulse = 1'b0; bus.start_pulse = 1'b1; tick();
        bus.start_pulse = 1'b0; bus.edge_pulse = 1'b1; tick();
        bus.edge_pulse = 1'b0;
        check("t3_busy", 64'(bus.busy), 64'h1);
        bus.locked = 1'b1;
        send_bits(32'h3F1, 6, 0);
`ifndef ADC_AVG_EN
        check("t3_data", 64'(bus.data_out), 64'h3F1);
`endif
        accept();

        // Back-to-back frames without acceptance.
        frame(32'h111);
        frame(32'h222);
`ifndef ADC_AVG_EN
        check("t4_data", 64'(bus.data_out), 64'h222);
        check("t4_valid", 64'(bus.data_valid), 64'h1);
        check("t4_ovr", 64'(bus.overrun), 64'h1);
`endif
        bus.overrun_clr = 1'b1; tick(); bus.overrun_clr = 1'b0;
        check("t4_clr", 64'(bus.overrun), 64'h0);

        // Asynchronous reset while a word is pending.
        #3 nrst = 1'b0;
        #1;
        check("t1_data", 64'(bus.data_out), 64'h0);
        check("t1_valid", 64'(bus.data_valid), 64'h0);
        check("t1_busy", 64'(bus.busy), 64'h0);
        check("t1_ovr", 64'(bus.overrun), 64'h0);
        tick();
        nrst = 1'b1;
        tick();

        // Aborted frame followed by a full one.
        do_start();
        send_bits(32'($urandom), 6, 0);
        frame(32'h123);
`ifndef ADC_AVG_EN
        check("t5_data", 64'(bus.data_out), 64'h123);
`endif
        accept();

`ifdef ADC_AVG_EN
        pulse_reset();
        frame(32'd100);
        check("t6_f1", 64'(bus.data_valid), 64'h0);
        frame(32'd101);
        check("t6_f2", 64'(bus.data_valid), 64'h0);
        frame(32'd102);
        check("t6_f3", 64'(bus.data_valid), 64'h0);
        frame(32'd104);
        check("t6_valid", 64'(bus.data_valid), 64'h1);
        check("t6_data", 64'(bus.data_out), 64'd101);
        accept();
`endif

        // Random phase.
        for (int c = 0; c < 3000; c++) begin
            bus.locked      = ($urandom_range(0, 9) != 0);
            bus.start_pulse = ($urandom_range(0, 79) == 0);
            bus.edge_pulse  = 1'($urandom);
            bus.sdata       = 1'($urandom);
            bus.data_ready  = ($urandom_range(0, 3) == 0);
            bus.overrun_clr = ($urandom_range(0, 15) == 0);
            if (c == 1500) pulse_reset();
            else tick();
        end

        bus.start_pulse = 1'b0; bus.edge_pulse = 1'b0;
        bus.data_ready = 1'b0; bus.overrun_clr = 1'b0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
